// File: rtl/ram_seq_init_config_pkg.sv
// ram_seq_init_config_pkg: shared types for the sequentially initialised register-file RAM.
package ram_seq_init_config_pkg;
   typedef enum logic [1:0] {
      RAM_INIT_NONE = 2'd0,
      RAM_INIT_ZERO = 2'd1,
      RAM_INIT_SEQ  = 2'd2
   } ram_init_mode_t;
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } ram_init_state_t;
endpackage

// File: rtl/ram_seq_init_config_wr_priority.sv
// ram_wr_priority_resolve: picks the highest-index enabled write port that targets queryAddr.
module ram_wr_priority_resolve
   import ram_seq_init_config_pkg::*;
#(
   parameter int NUM_WR_PORTS = 4,
   parameter int INDEX = 5,
   parameter int WIDTH = 32
) (
   input  logic [INDEX-1:0] queryAddr,
   input  logic [NUM_WR_PORTS-1:0] wrEn,
   input  logic [NUM_WR_PORTS-1:0][INDEX-1:0] addrWr,
   input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0] dataWr,
   output logic hit,
   output logic [WIDTH-1:0] data
);
   always_comb begin
      hit = 1'b0;
      data = '0;
      for (int p = 0; p < NUM_WR_PORTS; p++)
         if (wrEn[p] && addrWr[p] == queryAddr) begin
            hit = 1'b1;
            data = dataWr[p];
         end
   end
endmodule

// File: rtl/ram_seq_init_config.sv
// ram_seq_init_config: multi-port register-file RAM with a multi-lane init sweep,
// deterministic write priority, optional write bypass and optional registered read.
module ram_seq_init_config
   import ram_seq_init_config_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int INDEX = 5,
   parameter int WIDTH = 32,
   parameter int NUM_WR_PORTS = 4,
   parameter int NUM_RD_PORTS = 8,
   parameter int RESET_MODE = 1,
   parameter int SEQ_START = 0,
   parameter int INIT_LANES = 1,
   parameter int READ_LATENCY = 0,
   parameter int WR_BYPASS = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic reinit_i,
   input  logic [NUM_WR_PORTS-1:0] writePortGated_i,
   input  logic [NUM_RD_PORTS-1:0] readPortGated_i,
   input  logic [NUM_RD_PORTS-1:0][INDEX-1:0] addr_i,
   output logic [NUM_RD_PORTS-1:0][WIDTH-1:0] data_o,
   input  logic [NUM_WR_PORTS-1:0][INDEX-1:0] addrWr_i,
   input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0] dataWr_i,
   input  logic [NUM_WR_PORTS-1:0] wrEn_i,
   output logic ramReady_o,
   output logic initBusy_o
);
   localparam int PW = $clog2(DEPTH + INIT_LANES) + 1;
   localparam ram_init_state_t RESET_STATE = (RESET_MODE == int'(RAM_INIT_NONE)) ? READY : INIT;
   ram_init_state_t state;
   logic [PW-1:0] initPtr;
   logic [NUM_WR_PORTS-1:0] wrEff;
   logic [WIDTH-1:0] memQ [DEPTH];
   function automatic logic inRange(input logic [INDEX-1:0] a);
      return {1'b0, a} < (INDEX+1)'(DEPTH);
   endfunction
   assign ramReady_o = (state == READY);
   assign initBusy_o = (state == INIT);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= RESET_STATE;
         initPtr <= '0;
      end else if (state == INIT) begin
         initPtr <= initPtr + PW'(INIT_LANES);
         if (int'(initPtr) + INIT_LANES >= DEPTH) state <= READY;
      end else if (reinit_i && RESET_MODE != int'(RAM_INIT_NONE)) begin
         state <= INIT;
         initPtr <= '0;
      end
   always_comb
      for (int p = 0; p < NUM_WR_PORTS; p++)
         wrEff[p] = wrEn_i[p] && !writePortGated_i[p] && state == READY && inRange(addrWr_i[p]);
   // Each entry resolves its own winning writer; the sweep lanes take precedence.
   for (genvar k = 0; k < DEPTH; k++) begin : gEntry
      logic hit;
      logic sweepHit;
      logic [WIDTH-1:0] wrData;
      logic [WIDTH-1:0] entry;
      ram_wr_priority_resolve #(
         .NUM_WR_PORTS(NUM_WR_PORTS),
         .INDEX(INDEX),
         .WIDTH(WIDTH)
      ) uRes (
         .queryAddr(INDEX'(k)),
         .wrEn(wrEff),
         .addrWr(addrWr_i),
         .dataWr(dataWr_i),
         .hit(hit),
         .data(wrData)
      );
      assign sweepHit = state == INIT && int'(initPtr) <= k && k < int'(initPtr) + INIT_LANES;
      always_ff @(posedge clk)
         if (sweepHit) entry <= (RESET_MODE == int'(RAM_INIT_SEQ)) ? WIDTH'(SEQ_START + k) : '0;
         else if (hit) entry <= wrData;
      assign memQ[k] = entry;
   end
   for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : gRead
      logic bypHit;
      logic [WIDTH-1:0] bypData;
      logic [WIDTH-1:0] rdVal;
      ram_wr_priority_resolve #(
         .NUM_WR_PORTS(NUM_WR_PORTS),
         .INDEX(INDEX),
         .WIDTH(WIDTH)
      ) uByp (
         .queryAddr(addr_i[r]),
         .wrEn(wrEff),
         .addrWr(addrWr_i),
         .dataWr(dataWr_i),
         .hit(bypHit),
         .data(bypData)
      );
      assign rdVal = !inRange(addr_i[r]) ? '0 : (WR_BYPASS != 0 && bypHit) ? bypData : memQ[addr_i[r]];
      if (READ_LATENCY == 0) begin : gComb
         assign data_o[r] = (readPortGated_i[r] || state == INIT) ? '0 : rdVal;
      end else begin : gReg
         logic [WIDTH-1:0] rdReg;
         always_ff @(posedge clk or posedge reset)
            if (reset) rdReg <= '0;
            else if (state == INIT) rdReg <= '0;
            else if (!readPortGated_i[r]) rdReg <= rdVal;
         assign data_o[r] = (state == INIT) ? '0 : rdReg;
      end
   end
endmodule

// File: tb/tb_ram_seq_init_config.sv
// tb_ram_seq_init_config: four RAM configurations driven in lockstep and checked against
// an array-level model every cycle, plus hand-computed spot values.
module tb_ram_seq_init_config;
   localparam int P_DEPTH [4] = '{32, 30, 32, 32};
   localparam int P_MODE  [4] = '{2, 1, 1, 2};
   localparam int P_SEQ   [4] = '{8, 0, 0, 100};
   localparam int P_LANES [4] = '{1, 4, 2, 4};
   localparam int P_LAT   [4] = '{0, 0, 1, 1};
   localparam int P_BYP   [4] = '{0, 1, 1, 0};
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reinit;
   logic [3:0] wrEn, wrGated;
   logic [7:0] rdGated;
   logic [7:0][4:0] addr;
   logic [3:0][4:0] addrWr;
   logic [3:0][31:0] dataWr;
   logic [7:0][31:0] dOut [4];
   logic [3:0] ready, busy;
   logic [31:0] mMem [4][32];
   logic [31:0] mReg [4][8];
   bit mInit [4];
   int mPtr [4];
   int len [4];
   bit chkOn = 1'b0;
   int nVec = 0;
   int nErr = 0;
   always #5 clk = ~clk;
   ram_seq_init_config #(.DEPTH(32), .RESET_MODE(2), .SEQ_START(8), .INIT_LANES(1),
      .READ_LATENCY(0), .WR_BYPASS(0)) dutA (
      .clk(clk), .reset(reset), .reinit_i(reinit), .writePortGated_i(wrGated),
      .readPortGated_i(rdGated), .addr_i(addr), .data_o(dOut[0]), .addrWr_i(addrWr),
      .dataWr_i(dataWr), .wrEn_i(wrEn), .ramReady_o(ready[0]), .initBusy_o(busy[0]));
   ram_seq_init_config #(.DEPTH(30), .RESET_MODE(1), .SEQ_START(0), .INIT_LANES(4),
      .READ_LATENCY(0), .WR_BYPASS(1)) dutB (
      .clk(clk), .reset(reset), .reinit_i(reinit), .writePortGated_i(wrGated),
      .readPortGated_i(rdGated), .addr_i(addr), .data_o(dOut[1]), .addrWr_i(addrWr),
      .dataWr_i(dataWr), .wrEn_i(wrEn), .ramReady_o(ready[1]), .initBusy_o(busy[1]));
   ram_seq_init_config #(.DEPTH(32), .RESET_MODE(1), .SEQ_START(0), .INIT_LANES(2),
      .READ_LATENCY(1), .WR_BYPASS(1)) dutC (
      .clk(clk), .reset(reset), .reinit_i(reinit), .writePortGated_i(wrGated),
      .readPortGated_i(rdGated), .addr_i(addr), .data_o(dOut[2]), .addrWr_i(addrWr),
      .dataWr_i(dataWr), .wrEn_i(wrEn), .ramReady_o(ready[2]), .initBusy_o(busy[2]));
   ram_seq_init_config #(.DEPTH(32), .RESET_MODE(2), .SEQ_START(100), .INIT_LANES(4),
      .READ_LATENCY(1), .WR_BYPASS(0)) dutD (
      .clk(clk), .reset(reset), .reinit_i(reinit), .writePortGated_i(wrGated),
      .readPortGated_i(rdGated), .addr_i(addr), .data_o(dOut[3]), .addrWr_i(addrWr),
      .dataWr_i(dataWr), .wrEn_i(wrEn), .ramReady_o(ready[3]), .initBusy_o(busy[3]));
   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask
   // Value a read of address a sees this cycle, including the newest same-cycle write when bypassing.
   function automatic logic [31:0] readVal(int i, logic [4:0] a);
      if (int'(a) >= P_DEPTH[i]) return 32'h0;
      if (P_BYP[i] != 0)
         for (int p = 3; p >= 0; p--)
            if (wrEn[p] && !wrGated[p] && addrWr[p] == a) return dataWr[p];
      return mMem[i][a];
   endfunction
   function automatic logic [31:0] expOut(int i, int r);
      if (mInit[i]) return 32'h0;
      if (P_LAT[i] != 0) return mReg[i][r];
      return rdGated[r] ? 32'h0 : readVal(i, addr[r]);
   endfunction
   always @(posedge clk or posedge reset)
      for (int i = 0; i < 4; i++)
         if (reset) begin
            mInit[i] = 1'b1;
            mPtr[i] = 0;
            for (int r = 0; r < 8; r++) mReg[i][r] = 32'h0;
         end else if (mInit[i]) begin
            for (int l = 0; l < P_LANES[i]; l++)
               if (mPtr[i] + l < P_DEPTH[i])
                  mMem[i][mPtr[i] + l] = (P_MODE[i] == 2) ? 32'(P_SEQ[i] + mPtr[i] + l) : 32'h0;
            mPtr[i] += P_LANES[i];
            if (mPtr[i] >= P_DEPTH[i]) mInit[i] = 1'b0;
            for (int r = 0; r < 8; r++) mReg[i][r] = 32'h0;
         end else begin
            for (int r = 0; r < 8; r++)
               if (!rdGated[r]) mReg[i][r] = readVal(i, addr[r]);
            for (int p = 0; p < 4; p++)
               if (wrEn[p] && !wrGated[p] && int'(addrWr[p]) < P_DEPTH[i]) mMem[i][addrWr[p]] = dataWr[p];
            if (reinit) begin
               mInit[i] = 1'b1;
               mPtr[i] = 0;
            end
         end
   always @(negedge clk)
      if (chkOn)
         for (int i = 0; i < 4; i++) begin
            cmp($sformatf("dut%0d.ramReady", i), {31'b0, ready[i]}, {31'b0, !mInit[i]});
            cmp($sformatf("dut%0d.initBusy", i), {31'b0, busy[i]}, {31'b0, mInit[i]});
            for (int r = 0; r < 8; r++)
               cmp($sformatf("dut%0d.data%0d", i, r), dOut[i][r], expOut(i, r));
         end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // Counts edges until each instance reports ready; optionally pulses reinit mid-sweep.
   task automatic runSweep(input int pulseAt);
      for (int i = 0; i < 4; i++) len[i] = 0;
      for (int n = 1; n <= 40; n++) begin
         tick;
         for (int i = 0; i < 4; i++)
            if (ready[i] && len[i] == 0) len[i] = n;
         if (n == 6) wrEn = '0;
         reinit = (n == pulseAt);
      end
   endtask
   initial begin
      reinit = 1'b0;
      wrEn = '0;
      wrGated = '0;
      rdGated = '0;
      addr = '0;
      addrWr = '0;
      dataWr = '0;
      addr[0] = 5'd5;
      addr[1] = 5'd31;
      addr[2] = 5'd3;
      addrWr[0] = 5'd3;
      dataWr[0] = 32'hDEAD;
      wrEn[0] = 1'b1;
      tick;
      chkOn = 1'b1;
      tick;
      reset = 1'b0;
      repeat (12) tick;
      cmp("busyMidSweep", {31'b0, busy[0]}, 32'd1);
      reset = 1'b1;
      tick;
      cmp("readyInReset", {31'b0, ready[0]}, 32'd0);
      tick;
      reset = 1'b0;
      runSweep(0);
      cmp("sweepLenA", len[0], 32);
      cmp("sweepLenB", len[1], 8);
      cmp("sweepLenC", len[2], 16);
      cmp("sweepLenD", len[3], 8);
      cmp("seqA5", dOut[0][0], 32'd13);
      cmp("seqA31", dOut[0][1], 32'd39);
      cmp("initWrIgnoredA", dOut[0][2], 32'd11);
      cmp("initWrIgnoredB", dOut[1][2], 32'd0);
      cmp("seqD5", dOut[3][0], 32'd105);
      addr[3] = 5'd7;
      addr[4] = 5'd4;
      addr[5] = 5'd30;
      addrWr = {5'd7, 5'd4, 5'd30, 5'd7};
      dataWr = {32'h5555, 32'h1234, 32'h777, 32'hAAAA};
      wrGated = 4'b0100;
      wrEn = 4'b1111;
      tick;
      cmp("conflictA", dOut[0][3], 32'h5555);
      cmp("gatedWrA", dOut[0][4], 32'd12);
      cmp("oobInRangeA", dOut[0][5], 32'h777);
      cmp("oobReadB", dOut[1][5], 32'd0);
      cmp("gatedWrB", dOut[1][4], 32'd0);
      wrEn = '0;
      wrGated = '0;
      tick;
      cmp("conflictB", dOut[1][3], 32'h5555);
      addr[6] = 5'd9;
      addrWr[1] = 5'd9;
      dataWr[1] = 32'hBEEF;
      wrEn = 4'b0010;
      tick;
      cmp("bypassRegC", dOut[2][6], 32'hBEEF);
      cmp("noBypassRegD", dOut[3][6], 32'h6D);
      wrEn = '0;
      tick;
      cmp("afterWriteD", dOut[3][6], 32'hBEEF);
      rdGated[7] = 1'b1;
      addr[7] = 5'd9;
      tick;
      cmp("gateHoldD", dOut[3][7], 32'h64);
      cmp("gateZeroA", dOut[0][7], 32'd0);
      rdGated[7] = 1'b0;
      tick;
      cmp("ungateD", dOut[3][7], 32'hBEEF);
      reinit = 1'b1;
      wrEn = 4'b0001;
      addrWr[0] = 5'd2;
      dataWr[0] = 32'h99;
      tick;
      reinit = 1'b0;
      wrEn = '0;
      cmp("reinitDropA", {31'b0, ready[0]}, 32'd0);
      runSweep(5);
      cmp("resweepLenA", len[0], 32);
      cmp("resweepLenB", len[1], 8);
      cmp("resweepLenC", len[2], 16);
      cmp("resweepLenD", len[3], 8);
      tick;
      cmp("resweepA7", dOut[0][3], 32'd15);
      cmp("resweepC9", dOut[2][6], 32'd0);
      repeat (2) tick;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
